// File: rtl/vga_scanout.sv
// 640x480@60 raster scanner for the 160x120 3-bit framebuffer; each logical pixel is shown as a 4x4 block.
// Optional build macro VGA_SCANOUT_BORDER_EN forces the outermost logical rows/columns to white.
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        Clock,
  input  logic        Resetn,
  output logic [14:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic        frame_start,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // y*160 + x built from shifts so no multiplier is inferred
  function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
    logic [14:0] yw;
    yw = {8'd0, py};
    return (yw << 7) + (yw << 5) + {7'd0, px};
  endfunction

  function automatic logic [7:0] expand(input logic bit_in);
    return {8{bit_in}};
  endfunction

  logic       ph;
  logic       tick;
  logic [9:0] h;
  logic [9:0] v;
  logic [7:0] x;
  logic [6:0] y;
  logic       vis;
  logic       hs_n;
  logic       vs_n;

  assign tick = ph;
  assign x    = h[9:2];
  assign y    = v[8:2];
  assign vis  = (h < H_VIS) && (v < V_VIS);
  assign hs_n = !((h >= HS_START) && (h < HS_END));
  assign vs_n = !((v >= VS_START) && (v < VS_END));

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      ph <= 1'b0;
      h  <= '0;
      v  <= '0;
    end else begin
      ph <= ~ph;
      if (tick) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn)
      frame_start <= 1'b0;
    else
      frame_start <= tick && (h == H_LAST) && (v == V_LAST);
  end

  // ---- stage p0: RAM address launch and delayed raster flags ----
  logic vld_p0;
  logic hs_p0;
  logic vs_p0;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      rd_addr <= '0;
      vld_p0  <= 1'b0;
      hs_p0   <= 1'b1;
      vs_p0   <= 1'b1;
    end else if (tick) begin
      rd_addr <= vis ? pix_addr(x, y) : '0;
      vld_p0  <= vis;
      hs_p0   <= hs_n;
      vs_p0   <= vs_n;
    end
  end

  logic [2:0] pix;

`ifdef VGA_SCANOUT_BORDER_EN
  logic border_p0;

  always_ff @(posedge Clock) begin
    if (!Resetn)
      border_p0 <= 1'b0;
    else if (tick)
      border_p0 <= (x == 8'd0) || (x == 8'd159) || (y == 7'd0) || (y == 7'd119);
  end

  assign pix = border_p0 ? 3'b111 : rd_data;
`else
  assign pix = rd_data;
`endif

  // ---- stage p1: pin registers; rd_data has settled during the non-tick edge ----
  logic [7:0] r_p1;
  logic [7:0] g_p1;
  logic [7:0] b_p1;
  logic       hs_p1;
  logic       vs_p1;
  logic       vld_p1;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_p1   <= '0;
      g_p1   <= '0;
      b_p1   <= '0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      vld_p1 <= 1'b0;
    end else if (tick) begin
      r_p1   <= vld_p0 ? expand(pix[2]) : 8'h00;
      g_p1   <= vld_p0 ? expand(pix[1]) : 8'h00;
      b_p1   <= vld_p0 ? expand(pix[0]) : 8'h00;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      vld_p1 <= vld_p0;
    end
  end

  assign VGA_R       = r_p1;
  assign VGA_G       = g_p1;
  assign VGA_B       = b_p1;
  assign VGA_HS      = hs_p1;
  assign VGA_VS      = vs_p1;
  assign VGA_BLANK_N = vld_p1;
  assign VGA_SYNC_N  = 1'b0;
  // pins update when ph goes 1->0, so the DAC's rising edge lands mid-pixel
  assign VGA_CLK     = ph;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with a shortened vertical frame (12 lines) and full-width lines.
module tb_vga_scanout;

  localparam int VV = 8;
  localparam int VF = 1;
  localparam int VSY = 2;
  localparam int VB = 1;
  localparam int VT = VV + VF + VSY + VB;
  localparam int HT = 800;
  localparam int FRAME_CLK = HT * VT * 2;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data = 3'd0;
  logic        frame_start;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

  always #5 Clock = ~Clock;

  vga_scanout #(
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_start(frame_start), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
  );

  logic ram_zero = 1'b0;

  function automatic logic [2:0] ram_fn(input logic [14:0] a);
    logic [2:0] t;
    t = a[2:0] + a[5:3] + 3'd5;
    return t;
  endfunction

  // synchronous framebuffer RAM: data valid one Clock after the address
  always @(posedge Clock) rd_data <= ram_zero ? 3'd0 : ram_fn(rd_addr);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bl;
  } pins_t;

  pins_t sb[$];
  int    fs_times[$];
  int    errors = 0;
  int    checks = 0;
  int    hm, vm, ncyc;
  logic  ph_m;
  int    hs_low, blank_hi, vs_low, white_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  function automatic pins_t rst_pins();
    pins_t p;
    p.r = 8'h00; p.g = 8'h00; p.b = 8'h00;
    p.hs = 1'b1; p.vs = 1'b1; p.bl = 1'b0;
    return p;
  endfunction

  function automatic int exp_addr(input int h, input int v);
    return (h < 640 && v < VV) ? (v / 4) * 160 + h / 4 : 0;
  endfunction

  function automatic pins_t model(input int h, input int v);
    pins_t      p;
    logic       vis;
    logic       bord;
    logic [2:0] c;
    int         x, y;
    vis  = (h < 640) && (v < VV);
    x    = h / 4;
    y    = v / 4;
    bord = 1'b0;
`ifdef VGA_SCANOUT_BORDER_EN
    bord = (x == 0) || (x == 159) || (y == 0) || (y == 119);
`endif
    c = bord ? 3'b111 : (ram_zero ? 3'b000 : ram_fn(15'(exp_addr(h, v))));
    if (!vis) c = 3'b000;
    p.r  = {8{c[2]}};
    p.g  = {8{c[1]}};
    p.b  = {8{c[0]}};
    p.hs = !(h >= 656 && h < 752);
    p.vs = !(v >= VV + VF && v < VV + VF + VSY);
    p.bl = vis;
    return p;
  endfunction

  task automatic check_pins(input pins_t e);
    chk("vga_r", 32'(VGA_R), 32'(e.r));
    chk("vga_g", 32'(VGA_G), 32'(e.g));
    chk("vga_b", 32'(VGA_B), 32'(e.b));
    chk("vga_hs", 32'(VGA_HS), 32'(e.hs));
    chk("vga_vs", 32'(VGA_VS), 32'(e.vs));
    chk("blank_n", 32'(VGA_BLANK_N), 32'(e.bl));
  endtask

  task automatic check_reset();
    check_pins(rst_pins());
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_vga_clk", 32'(VGA_CLK), 32'd0);
    chk("sync_n", 32'(VGA_SYNC_N), 32'd0);
  endtask

  task automatic model_reset();
    ph_m = 1'b0;
    hm   = 0;
    vm   = 0;
    ncyc = 0;
    sb.delete();
    sb.push_back(rst_pins());
  endtask

  task automatic step();
    logic  was_tick;
    pins_t e;
    was_tick = ph_m;
    @(posedge Clock);
    #1;
    ncyc++;
    ph_m = ~ph_m;
    chk("vga_clk", 32'(VGA_CLK), 32'(ph_m));
    chk("frame_start", 32'(frame_start), 32'(was_tick && hm == HT - 1 && vm == VT - 1));
    if (frame_start) fs_times.push_back(ncyc);
    if (was_tick) begin
      e = (sb.size() > 0) ? sb.pop_front() : rst_pins();
      check_pins(e);
      chk("rd_addr", 32'(rd_addr), 32'(exp_addr(hm, vm)));
      if (hm == 4 && vm == 4) chk("addr_4_4", 32'(rd_addr), 32'd161);
      if (hm == 636 && vm == 7) chk("addr_636_7", 32'(rd_addr), 32'd319);
      if (!VGA_HS) hs_low++;
      if (VGA_BLANK_N) blank_hi++;
      if (!VGA_VS) vs_low++;
      if (VGA_BLANK_N && VGA_R == 8'hFF && VGA_G == 8'hFF && VGA_B == 8'hFF) white_cnt++;
      sb.push_back(model(hm, vm));
      if (hm == HT - 1) begin
        hm = 0;
        vm = (vm == VT - 1) ? 0 : vm + 1;
      end else begin
        hm++;
      end
    end
  endtask

  initial begin
    int guard;
    int exp_white;

    // held in reset
    Resetn = 1'b0;
    repeat (3) begin
      @(posedge Clock);
      #1;
      check_reset();
    end
    Resetn = 1'b1;
    model_reset();

    // first visible colour appears at the second tick and holds for the 4x4 block width
    repeat (4) step();
    chk("tick2_r", 32'(VGA_R), 32'h0FF);
    chk("tick2_g", 32'(VGA_G), 32'h000);
    chk("tick2_b", 32'(VGA_B), 32'h0FF);
    chk("tick2_blank_n", 32'(VGA_BLANK_N), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      step();
      chk("hold_r", 32'(VGA_R), 32'h0FF);
      chk("hold_g", 32'(VGA_G), 32'h000);
      chk("hold_b", 32'(VGA_B), 32'h0FF);
    end

    // one full line window inside the visible lines
    guard = 0;
    while (!(hm == 0 && vm == 1 && ph_m == 1'b1) && guard < 5000) begin
      step();
      guard++;
    end
    if (guard >= 5000) timeout("align_line");
    hs_low = 0;
    blank_hi = 0;
    repeat (2 * HT) step();
    chk("hs_low_ticks", 32'(hs_low), 32'd96);
    chk("blank_hi_ticks", 32'(blank_hi), 32'd640);

    // first frame_start
    guard = 0;
    while (fs_times.size() < 1 && guard < FRAME_CLK + 100) begin
      step();
      guard++;
    end
    if (fs_times.size() < 1) timeout("first_frame_start");
    else chk("first_fs_clocks", 32'(fs_times[0]), 32'(FRAME_CLK));

    // second frame with an all-zero framebuffer
    if (ph_m != 1'b1) step();
    ram_zero = 1'b1;
    vs_low = 0;
    white_cnt = 0;
    guard = 0;
    while (fs_times.size() < 2 && guard < FRAME_CLK + 100) begin
      step();
      guard++;
    end
    if (fs_times.size() < 2) timeout("second_frame_start");
    else chk("fs_period", 32'(fs_times[1] - fs_times[0]), 32'(FRAME_CLK));
    chk("vs_low_ticks", 32'(vs_low), 32'd1600);
`ifdef VGA_SCANOUT_BORDER_EN
    exp_white = 4 * 640 + (VV - 4) * 8;
`else
    exp_white = 0;
`endif
    chk("white_pixels", 32'(white_cnt), 32'(exp_white));

    // reset pulse in the middle of line 5
    guard = 0;
    while (!(vm == 5 && hm == 400) && guard < FRAME_CLK) begin
      step();
      guard++;
    end
    if (guard >= FRAME_CLK) timeout("align_midline");
    Resetn = 1'b0;
    @(posedge Clock);
    #1;
    check_reset();
    Resetn = 1'b1;
    model_reset();
    repeat (1700) step();
    chk("no_fs_after_reset", 32'(fs_times.size()), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
